// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one finished functional-unit result per cycle and broadcasts it
// one cycle later. Round-robin by default; define CDB_OLDEST_FIRST_EN for oldest-ROB-tag-first.
module cdb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int TAG_BITS   = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_BITS   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [TAG_BITS-1:0]            rob_head,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*TAG_BITS-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_value,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           cdb_valid,
    output logic [TAG_BITS-1:0]            cdb_tag,
    output logic [DATA_WIDTH-1:0]          cdb_value,
    output logic [CNT_BITS-1:0]            conflict_cnt
);

    localparam int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_BITS:0]   NUM_REQ_W = NUM_REQ[PTR_BITS:0];
    localparam logic [PTR_BITS-1:0] LAST_IDX  = PTR_BITS'(NUM_REQ - 1);

    logic [TAG_BITS-1:0]   tag_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0] value_arr [NUM_REQ];

    logic [PTR_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  cdb_valid_q, cdb_valid_d;
    logic [TAG_BITS-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_value_q, cdb_value_d;
    logic [CNT_BITS-1:0]   conflict_cnt_q, conflict_cnt_d;

    logic [PTR_BITS-1:0]   grant_idx;
    logic                  grant_found;
    logic                  grant_en;
    logic                  conflict;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign tag_arr[gi]   = req_tag[gi*TAG_BITS +: TAG_BITS];
            assign value_arr[gi] = req_value[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

`ifdef CDB_OLDEST_FIRST_EN
    // Age is distance from the ROB head, modulo the tag space; smallest age is oldest.
    logic [TAG_BITS-1:0] age_arr [NUM_REQ];
    logic [TAG_BITS-1:0] best_age;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_age
            assign age_arr[gi] = tag_arr[gi] - rob_head;
        end
    endgenerate

    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        best_age    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && (!grant_found || (age_arr[i] < best_age))) begin
                grant_idx   = PTR_BITS'(i);
                grant_found = 1'b1;
                best_age    = age_arr[i];
            end
        end
    end
`else
    logic unused_rob_head;
    assign unused_rob_head = ^rob_head;

    logic [PTR_BITS:0]   cand;
    logic [PTR_BITS-1:0] cand_idx;

    // Walk from rr_ptr upward, wrapping at NUM_REQ rather than at the pointer's binary range.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_BITS+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            cand_idx = cand[PTR_BITS-1:0];
            if (!grant_found && req_valid[cand_idx]) begin
                grant_idx   = cand_idx;
                grant_found = 1'b1;
            end
        end
    end
`endif

    assign grant_en = rst_n && !flush && grant_found;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_idx == PTR_BITS'(gi));
        end
    endgenerate

    assign conflict = ($countones(req_valid) >= 2);

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        cdb_valid_d    = 1'b0;
        cdb_tag_d      = cdb_tag_q;
        cdb_value_d    = cdb_value_q;
        conflict_cnt_d = conflict_cnt_q;
        if (grant_en) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = tag_arr[grant_idx];
            cdb_value_d = value_arr[grant_idx];
            rr_ptr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
        if (conflict && (conflict_cnt_q != {CNT_BITS{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            cdb_valid_q    <= 1'b0;
            cdb_tag_q      <= '0;
            cdb_value_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_tag_q      <= cdb_tag_d;
            cdb_value_q    <= cdb_value_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_tag      = cdb_tag_q;
    assign cdb_value    = cdb_value_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a cycle-level behavioural model of grant selection,
// broadcast timing and the saturating conflict counter.
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int TB = 5;
    localparam int DW = 32;
    localparam int CB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [TB-1:0]     rob_head;
    logic [N-1:0]      req_valid;
    logic [N*TB-1:0]   req_tag;
    logic [N*DW-1:0]   req_value;
    logic [N-1:0]      req_ready;
    logic              cdb_valid;
    logic [TB-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_value;
    logic [CB-1:0]     conflict_cnt;

    cdb_arbiter #(.NUM_REQ(N), .TAG_BITS(TB), .DATA_WIDTH(DW), .CNT_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head(rob_head),
        .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    int            m_ptr = 0;
    int            m_cnt = 0;
    bit            m_cv  = 1'b0;
    logic [TB-1:0] m_tag = '0;
    logic [DW-1:0] m_val = '0;
    int            last_grant = -1;
    logic [N-1:0]  last_rdy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [TB-1:0] tag_of(input int i);
        return req_tag[i*TB +: TB];
    endfunction

    function automatic logic [DW-1:0] val_of(input int i);
        return req_value[i*DW +: DW];
    endfunction

    // Which requester should win this cycle, or -1.
    function automatic int model_grant();
        int best;
        int best_age;
        int age;
        best = -1;
        best_age = 0;
        if (!rst_n || flush) return -1;
`ifdef CDB_OLDEST_FIRST_EN
        for (int i = 0; i < N; i++) begin
            age = (int'(tag_of(i)) - int'(rob_head) + (1 << TB)) % (1 << TB);
            if (req_valid[i] && (best < 0 || age < best_age)) begin
                best = i;
                best_age = age;
            end
        end
`else
        age = 0;
        for (int k = 0; k < N; k++) begin
            if (best < 0 && req_valid[(m_ptr + k) % N]) best = (m_ptr + k) % N;
        end
`endif
        return best;
    endfunction

    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        #2;
        g = model_grant();
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        last_rdy = req_ready;
        check("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_cnt = 0; m_cv = 1'b0; m_tag = '0; m_val = '0;
        end else begin
            if ($countones(req_valid) >= 2 && m_cnt < (1 << CB) - 1) m_cnt++;
            if (g >= 0) begin
                m_cv = 1'b1; m_tag = tag_of(g); m_val = val_of(g);
                m_ptr = (g + 1) % N;
            end else begin
                m_cv = 1'b0;
            end
        end
        #1;
        check("cdb_valid", cdb_valid, m_cv);
        check("cdb_tag", cdb_tag, m_tag);
        check("cdb_value", cdb_value, m_val);
        check("conflict_cnt", conflict_cnt, m_cnt);
        last_grant = g;
    endtask

    task automatic set_req(input int i, input logic [TB-1:0] t, input logic [DW-1:0] v);
        req_tag[i*TB +: TB]   = t;
        req_value[i*DW +: DW] = v;
    endtask

    initial begin
        logic [N-1:0] rr_seq [4];
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;

        rst_n = 1'b0; flush = 1'b0; rob_head = '0;
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) set_req(i, TB'(i + 3), DW'($urandom));

        // Reset held with all requests asserted
        cycle(); cycle();
        check("reset_valid", cdb_valid, 1'b0);
        check("reset_cnt", conflict_cnt, 0);

        // Single requester
        rst_n = 1'b1;
        req_valid = 3'b010;
        set_req(1, 5'd7, 32'hDEAD_BEEF);
        cycle();
        check("single_ready", last_rdy, 3'b010);
        check("single_tag", cdb_tag, 5'd7);
        check("single_value", cdb_value, 32'hDEAD_BEEF);

        // All valid straight after: pointer should now favour requester 2
        req_valid = 3'b111;
        cycle();
`ifndef CDB_OLDEST_FIRST_EN
        check("ptr_after_single", last_rdy, 3'b100);
`endif
        cycle(); cycle();

        // Round-robin from reset
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
`ifndef CDB_OLDEST_FIRST_EN
            check("rr_grant", last_rdy, rr_seq[k]);
`endif
        end
        check("rr_cnt", conflict_cnt, 4);

        // Flush
        req_valid = 3'b101;
        flush = 1'b1;
        cycle();
        check("flush_ready", last_rdy, 3'b000);
        check("flush_valid", cdb_valid, 1'b0);
        flush = 1'b0;
        cycle();

        // Counter saturation
        req_valid = 3'b111;
        for (int k = 0; k < 20; k++) cycle();
        check("sat_cnt", conflict_cnt, 15);

`ifdef CDB_OLDEST_FIRST_EN
        rob_head = 5'd30;
        set_req(0, 5'd2, 32'h0); set_req(1, 5'd31, 32'h1); set_req(2, 5'd5, 32'h2);
        req_valid = 3'b111;
        cycle(); check("oldest_1", last_rdy, 3'b010);
        req_valid = 3'b101;
        cycle(); check("oldest_2", last_rdy, 3'b001);
        req_valid = 3'b100;
        cycle(); check("oldest_3", last_rdy, 3'b100);
`endif

        // Random traffic respecting the valid/ready hold rule
        req_valid = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && last_grant == i) begin
                    if ($urandom_range(1, 0) == 0) req_valid[i] = 1'b0;
                    else set_req(i, TB'($urandom), DW'($urandom));
                end else if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i] = 1'b1;
                    set_req(i, TB'($urandom), DW'($urandom));
                end
            end
            rob_head = TB'($urandom);
            flush = ($urandom_range(9, 0) == 0);
            rst_n = ($urandom_range(49, 0) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
